// File: rtl/spi_slave_frontend_pkg.sv
// Shared definitions for the SPI slave front end: word/fill defaults and
// the frame-state encoding used by the top-level FSM.
package spi_slave_frontend_pkg;

    localparam int          DEF_WIDTH_SPI_WORD = 8;
    localparam logic [7:0]  DEF_TX_FILL        = 8'h00;

    // state    | meaning
    // S_IDLE   | chip select high (or not yet seen a clean falling edge); sck ignored
    // S_ACTIVE | frame in progress; shifting on sck edges, MISO driven
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } frame_state_t;

endpackage

// File: rtl/spi_slave_frontend_fifo.sv
// Show-ahead synchronous FIFO. The head word is presented on pop_data while
// not empty (zero when empty). A push into a full FIFO is accepted only when
// a pop happens in the same cycle; a pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Pointer update; reset flushes the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (DEPTH_LOG2 + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_LOG2 + 1)'(1);
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_slave_frontend.sv
// SPI mode-0 slave, MSB first, oversampled in the clk domain. Received words
// land in a show-ahead RX FIFO; transmit words come from a TX FIFO, with
// TX_FILL substituted (and flagged) whenever the TX FIFO runs dry.
module spi_slave_frontend
    import spi_slave_frontend_pkg::*;
#(
    parameter int WIDTH_SPI_WORD = DEF_WIDTH_SPI_WORD,
    parameter int RX_DEPTH_LOG2  = 4,
    parameter int TX_DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES    = 2,
    parameter logic [WIDTH_SPI_WORD-1:0] TX_FILL = WIDTH_SPI_WORD'(DEF_TX_FILL),
    parameter int WIDTH_COUNT    = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    input  logic                      chip_select_n,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    output logic [WIDTH_SPI_WORD-1:0] rx_word,
    input  logic                      rx_rd_req,
    output logic                      rx_empty,
    input  logic [WIDTH_SPI_WORD-1:0] tx_word,
    input  logic                      tx_wr_req,
    output logic                      tx_full,
    output logic                      tx_empty,
    output logic                      chip_select_n_sync,
    output logic [WIDTH_COUNT-1:0]    word_count,
    output logic                      rx_overflow,
    output logic                      tx_underflow
);

    localparam int CNT_W = (WIDTH_SPI_WORD > 2) ? $clog2(WIDTH_SPI_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH_SPI_WORD - 1);

    logic [SYNC_STAGES-1:0]    sck_pipe;
    logic [SYNC_STAGES-1:0]    mosi_pipe;
    logic [SYNC_STAGES-1:0]    cs_pipe;
    logic [SYNC_STAGES:0]      cs_valid;
    logic                      sck_d;
    logic                      cs_d;
    logic                      sck_s;
    logic                      mosi_s;
    logic                      cs_s;
    logic                      sck_rise;
    logic                      sck_fall;
    logic                      cs_fall;
    logic                      cs_rise;

    frame_state_t              state;
    logic [CNT_W-1:0]          bit_cnt;
    logic [WIDTH_SPI_WORD-1:0] rx_shift;
    logic [WIDTH_SPI_WORD-1:0] tx_shift;
    logic                      rx_push;
    logic                      rx_full;
    logic                      rx_ovf_evt;
    logic [WIDTH_SPI_WORD-1:0] tx_head;
    logic [WIDTH_SPI_WORD-1:0] tx_next;
    logic                      tx_load;
    logic                      tx_pop;

    // Pin synchronisers plus one extra stage on sck and cs for edge detect.
    // cs_valid marks when cs_d holds a real pin sample, so the reset value of
    // the chain cannot masquerade as a falling edge while cs_n is held low.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_pipe  <= '0;
            mosi_pipe <= '0;
            cs_pipe   <= '1;
            cs_valid  <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_pipe  <= (sck_pipe  << 1) | SYNC_STAGES'(spi_clk);
            mosi_pipe <= (mosi_pipe << 1) | SYNC_STAGES'(spi_mosi);
            cs_pipe   <= (cs_pipe   << 1) | SYNC_STAGES'(chip_select_n);
            cs_valid  <= {cs_valid[SYNC_STAGES-1:0], 1'b1};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    assign sck_s  = sck_pipe[SYNC_STAGES-1];
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];
    assign cs_s   = cs_pipe[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = cs_valid[SYNC_STAGES] & cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;

    assign chip_select_n_sync = cs_s;

    // TX word selection: frame entry, or the first sck fall after a word
    // boundary, pulls the next word from the TX FIFO (or TX_FILL if empty).
    always_comb begin
        tx_load = 1'b0;
        if (state == S_IDLE) begin
            tx_load = cs_fall;
        end else if (!cs_rise && sck_fall && bit_cnt == '0 && word_count != '0) begin
            tx_load = 1'b1;
        end
    end

    assign tx_next = tx_empty ? TX_FILL : tx_head;
    assign tx_pop  = tx_load & ~tx_empty;

    // A dropped RX word: push into a full FIFO with no effective pop.
    assign rx_ovf_evt = rx_push & rx_full & ~(rx_rd_req & ~rx_empty);

    // Frame FSM with receive/transmit shifters, counters and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            word_count   <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            rx_push      <= 1'b0;
            rx_overflow  <= 1'b0;
            tx_underflow <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            if (rx_ovf_evt) rx_overflow <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cs_fall) begin
                        state      <= S_ACTIVE;
                        bit_cnt    <= '0;
                        word_count <= '0;
                        tx_shift   <= tx_next;
                        if (tx_empty) tx_underflow <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (cs_rise) begin
                        // Partial word is abandoned; rx_shift is overwritten next frame.
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[WIDTH_SPI_WORD-2:0], mosi_s};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            rx_push <= 1'b1;
                            if (word_count != '1)
                                word_count <= word_count + WIDTH_COUNT'(1);
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        if (tx_load) begin
                            tx_shift <= tx_next;
                            if (tx_empty) tx_underflow <= 1'b1;
                        end else begin
                            tx_shift <= tx_shift << 1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign spi_miso_oe = (state == S_ACTIVE);
    assign spi_miso    = (state == S_ACTIVE) & tx_shift[WIDTH_SPI_WORD-1];

    sync_fifo #(
        .WIDTH      (WIDTH_SPI_WORD),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_rd_req),
        .pop_data  (rx_word),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    sync_fifo #(
        .WIDTH      (WIDTH_SPI_WORD),
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_wr_req),
        .push_data (tx_word),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Scoreboard bench for spi_slave_frontend: expected MISO bytes and RX words
// are queued as stimulus is planned and compared as the DUT produces them.
module tb_spi_slave_frontend;

    localparam int W     = 8;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;   // clk cycles per sck half period (16x)

    logic         clk = 1'b0;
    logic         reset;
    logic         spi_clk;
    logic         spi_mosi;
    logic         chip_select_n;
    logic         spi_miso;
    logic         spi_miso_oe;
    logic [W-1:0] rx_word;
    logic         rx_rd_req;
    logic         rx_empty;
    logic [W-1:0] tx_word;
    logic         tx_wr_req;
    logic         tx_full;
    logic         tx_empty;
    logic         chip_select_n_sync;
    logic [11:0]  word_count;
    logic         rx_overflow;
    logic         tx_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] miso_q[$];
    logic [W-1:0] rx_q[$];

    spi_slave_frontend #(
        .WIDTH_SPI_WORD (W),
        .RX_DEPTH_LOG2  (2),
        .TX_DEPTH_LOG2  (4),
        .SYNC_STAGES    (SYNC),
        .TX_FILL        (8'h00),
        .WIDTH_COUNT    (12)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .spi_clk            (spi_clk),
        .spi_mosi           (spi_mosi),
        .chip_select_n      (chip_select_n),
        .spi_miso           (spi_miso),
        .spi_miso_oe        (spi_miso_oe),
        .rx_word            (rx_word),
        .rx_rd_req          (rx_rd_req),
        .rx_empty           (rx_empty),
        .tx_word            (tx_word),
        .tx_wr_req          (tx_wr_req),
        .tx_full            (tx_full),
        .tx_empty           (tx_empty),
        .chip_select_n_sync (chip_select_n_sync),
        .word_count         (word_count),
        .rx_overflow        (rx_overflow),
        .tx_underflow       (tx_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk_n(2);
        reset = 1'b0;
        clk_n(1);
    endtask

    task automatic tx_push(input logic [W-1:0] v);
        tx_word   = v;
        tx_wr_req = 1'b1;
        clk_n(1);
        tx_wr_req = 1'b0;
    endtask

    task automatic frame_begin();
        chip_select_n = 1'b0;
        clk_n(HALF);
    endtask

    task automatic frame_end();
        clk_n(HALF);
        chip_select_n = 1'b1;
        clk_n(10);
    endtask

    // One word, MSB first; MISO sampled just before each rising sck edge.
    task automatic xfer(input logic [W-1:0] mo, input bit lat_chk);
        logic [W-1:0] got;
        got = '0;
        for (int i = W - 1; i >= 0; i--) begin
            spi_mosi = mo[i];
            clk_n(HALF);
            got[i]  = spi_miso;
            spi_clk = 1'b1;
            if (i == 0 && lat_chk) begin
                clk_n(SYNC + 3);
                chk("rx_latency", rx_empty, 1'b0);
                clk_n(HALF - (SYNC + 3));
            end else begin
                clk_n(HALF);
            end
            spi_clk = 1'b0;
        end
        if (miso_q.size() == 0) chk("miso_sb_empty", 1, 0);
        else chk("miso_byte", got, miso_q.pop_front());
    endtask

    task automatic partial_bits(input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = i[0];
            clk_n(HALF);
            spi_clk = 1'b1;
            clk_n(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (rx_q.size() > 0 && guard < 64) begin
            chk("rx_not_empty", rx_empty, 1'b0);
            chk("rx_word", rx_word, rx_q.pop_front());
            rx_rd_req = 1'b1;
            clk_n(1);
            rx_rd_req = 1'b0;
            guard++;
        end
        chk("rx_drained_empty", rx_empty, 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        spi_clk       = 1'b0;
        spi_mosi      = 1'b0;
        chip_select_n = 1'b1;
        rx_rd_req     = 1'b0;
        tx_word       = '0;
        tx_wr_req     = 1'b0;

        // Reset state
        do_reset();
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_tx_empty", tx_empty, 1'b1);
        chk("rst_tx_full", tx_full, 1'b0);
        chk("rst_oe", spi_miso_oe, 1'b0);
        chk("rst_miso", spi_miso, 1'b0);
        chk("rst_cs_sync", chip_select_n_sync, 1'b1);
        chk("rst_word_count", word_count, 0);
        chk("rst_rx_word", rx_word, 0);
        chk("rst_ovf", rx_overflow, 1'b0);
        chk("rst_unf", tx_underflow, 1'b0);
        clk_n(5);

        // RX single word with latency bound
        miso_q.push_back(8'h00);
        rx_q.push_back(8'hA5);
        frame_begin();
        chk("frame_oe", spi_miso_oe, 1'b1);
        xfer(8'hA5, 1'b1);
        frame_end();
        chk("idle_oe", spi_miso_oe, 1'b0);
        chk("rx1_word_count", word_count, 1);
        drain();

        // TX two words; RX order
        do_reset();
        tx_push(8'h3C);
        tx_push(8'hC3);
        chk("tx_loaded_not_empty", tx_empty, 1'b0);
        miso_q.push_back(8'h3C);
        miso_q.push_back(8'hC3);
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        frame_begin();
        xfer(8'h11, 1'b0);
        xfer(8'h22, 1'b0);
        frame_end();
        chk("tx_end_empty", tx_empty, 1'b1);
        chk("tx_word_count", word_count, 2);
        drain();

        // Underflow
        do_reset();
        chk("unf_before", tx_underflow, 1'b0);
        miso_q.push_back(8'h00);
        rx_q.push_back(8'h5A);
        frame_begin();
        xfer(8'h5A, 1'b0);
        frame_end();
        chk("unf_after", tx_underflow, 1'b1);
        drain();

        // Overflow: five words into a four-deep RX FIFO
        do_reset();
        frame_begin();
        for (int k = 1; k <= 5; k++) begin
            miso_q.push_back(8'h00);
            if (k <= 4) rx_q.push_back(8'(k));
            xfer(8'(k), 1'b0);
        end
        frame_end();
        chk("ovf_flag", rx_overflow, 1'b1);
        chk("ovf_word_count", word_count, 5);

        // Same-cycle pop and push while full: count stays four
        miso_q.push_back(8'h00);
        frame_begin();
        fork
            xfer(8'h06, 1'b0);
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge clk);
                    if (dut.rx_push) begin
                        seen = 1'b1;
                        chk("full_pop_head", rx_word, rx_q.pop_front());
                        rx_rd_req = 1'b1;
                        @(negedge clk);
                        rx_rd_req = 1'b0;
                        rx_q.push_back(8'h06);
                    end
                end
                if (!seen) chk("push_seen", 0, 1);
            end
        join
        frame_end();
        drain();
        chk("ovf_sticky", rx_overflow, 1'b1);

        // Abort after five bits, then a clean frame
        frame_begin();
        partial_bits(5);
        chip_select_n = 1'b1;
        clk_n(10);
        chk("abort_rx_empty", rx_empty, 1'b1);
        chk("abort_word_count", word_count, 0);
        chk("abort_oe", spi_miso_oe, 1'b0);
        miso_q.push_back(8'h00);
        rx_q.push_back(8'h7E);
        frame_begin();
        xfer(8'h7E, 1'b0);
        frame_end();
        drain();

        // Reset mid-word with data pending in TX
        tx_push(8'h81);
        tx_push(8'h42);
        frame_begin();
        partial_bits(3);
        chk("pre_rst_oe", spi_miso_oe, 1'b1);
        reset = 1'b1;
        clk_n(1);
        reset = 1'b0;
        chk("mid_rst_oe", spi_miso_oe, 1'b0);
        chk("mid_rst_tx_empty", tx_empty, 1'b1);
        chk("mid_rst_cs_sync", chip_select_n_sync, 1'b1);
        chk("mid_rst_ovf", rx_overflow, 1'b0);
        chk("mid_rst_unf", tx_underflow, 1'b0);
        chk("mid_rst_word_count", word_count, 0);
        chk("mid_rst_rx_empty", rx_empty, 1'b1);
        clk_n(10);
        chk("held_idle_oe", spi_miso_oe, 1'b0);
        chip_select_n = 1'b1;
        clk_n(10);
        tx_push(8'h5A);
        miso_q.push_back(8'h5A);
        rx_q.push_back(8'h96);
        frame_begin();
        xfer(8'h96, 1'b0);
        frame_end();
        chk("post_rst_word_count", word_count, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_frontend.md
Name: spi_slave_frontend

Overview:
- Single-clock SPI slave (mode 0, MSB first) that oversamples raw sck/mosi/cs_n in the system clock domain.
- Assembles received bytes into a show-ahead RX FIFO drained by the packetizer (rd_req/empty/word).
- Serialises bytes from a TX FIFO, filled by the packetizer's write path, onto MISO.
- Sits directly upstream of the packetizer, between the chip pins and the command decoder.

Parameters:
- WIDTH_SPI_WORD, 8: bits per SPI word.
- RX_DEPTH_LOG2, 4: RX FIFO depth = 2^RX_DEPTH_LOG2 words.
- TX_DEPTH_LOG2, 4: TX FIFO depth = 2^TX_DEPTH_LOG2 words.
- SYNC_STAGES, 2: synchronizer flops on sck, mosi, cs_n.
- TX_FILL, 8'h00: word shifted out when the TX FIFO is empty.
- WIDTH_COUNT, 12: width of the per-frame word counter.

Ports:
- clk  in  1  system clock; must be at least 8x the sck frequency.
- reset  in  1  synchronous, active-high reset.
- spi_clk  in  1  raw SPI clock, asynchronous.
- spi_mosi  in  1  raw MOSI, asynchronous.
- chip_select_n  in  1  raw CS, active low, asynchronous.
- spi_miso  out  1  MISO data.
- spi_miso_oe  out  1  MISO output enable; 1 while the frame is active.
- rx_word  out  WIDTH_SPI_WORD  head of RX FIFO (show-ahead).
- rx_rd_req  in  1  pop RX head at the end of this cycle.
- rx_empty  out  1  RX FIFO empty.
- tx_word  in  WIDTH_SPI_WORD  word to enqueue for transmit.
- tx_wr_req  in  1  push tx_word this cycle.
- tx_full  out  1  TX FIFO full.
- tx_empty  out  1  TX FIFO empty.
- chip_select_n_sync  out  1  synchronised CS.
- word_count  out  WIDTH_COUNT  words completed in the current frame.
- rx_overflow  out  1  sticky: a received word was dropped.
- tx_underflow  out  1  sticky: TX_FILL was sent because the TX FIFO was empty.

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - spi_miso=0, spi_miso_oe=0, rx_empty=1, tx_empty=1, tx_full=0.
  - chip_select_n_sync=1, word_count=0, rx_overflow=0, tx_underflow=0, rx_word=0.
  - Both FIFOs are flushed; bit counter and shift registers are cleared.
- Synchronisation:
  - sck, mosi and cs_n each pass through SYNC_STAGES flops.
  - One extra sck flop provides edge detect: rise = s & !s_d, fall = !s & s_d.
- Frame states, 2-state FSM:
  - IDLE -> ACTIVE on cs_sync falling.
  - ACTIVE -> IDLE on cs_sync rising.
  - Edges of sck are ignored in IDLE.
- On entry to ACTIVE:
  - bit_cnt=0, word_count=0.
  - tx_shift loads the TX head (popped), or TX_FILL if TX is empty; TX_FILL sets tx_underflow.
  - spi_miso_oe=1.
- Receive, on rise in ACTIVE:
  - rx_shift = {rx_shift[W-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches W-1, the assembled word is pushed into RX the next cycle, bit_cnt wraps to 0, and word_count increments (saturates at all-ones).
- Transmit, on fall in ACTIVE:
  - If bit_cnt==0 and word_count!=0 (a word boundary was just crossed), load the next TX word or TX_FILL, as on frame entry.
  - Otherwise shift tx_shift left by 1.
  - spi_miso = tx_shift[W-1] while ACTIVE, else 0.
- Receive latency: the RX word is visible on rx_word with rx_empty=0 at most SYNC_STAGES+3 clk cycles after the 8th raw sck rising edge.
- RX FIFO rules:
  - A pop while empty is ignored.
  - A push while full is dropped and sets rx_overflow, unless a pop occurs in the same cycle; then both take effect.
  - Push and pop in the same cycle while empty: the word is written and rx_empty deasserts the next cycle (no bypass).
- TX FIFO rules:
  - tx_wr_req while tx_full is ignored.
  - A same-cycle push and internal pop are both honoured.
- CS deassert mid-word: partial bits are discarded, bit_cnt=0, nothing is pushed, and spi_miso_oe=0 on the next cycle.
- word_count holds its value in IDLE until the next frame start.
- Sticky flags clear only on reset.
- Reset asserted mid-frame: all state returns to reset values on the next clk edge, and the FSM waits in IDLE for a fresh cs_n falling edge.

Decomposition:
- Shared include (spi_defs.vh): WIDTH_SPI_WORD default, TX_FILL default, frame-state encodings (S_IDLE=1'b0, S_ACTIVE=1'b1).
- Reuse the existing synchronizer module (Width=1, Stages=SYNC_STAGES) for the three pins.
- One new sub-module, sync_fifo (params WIDTH, DEPTH_LOG2; show-ahead; push/pop/full/empty), instantiated for RX and TX.

Test Plan:
- Reset: after reset, rx_empty=1, tx_empty=1, spi_miso_oe=0, word_count=0, flags=0.
- RX single word: clk=16x sck; CS low; send 0xA5 MSB first; CS high -> rx_word=0xA5, rx_empty=0, word_count=1; pop -> rx_empty=1.
- TX: preload 0x3C and 0xC3; 16-bit frame with MOSI=0x11,0x22 -> MISO bits 0x3C then 0xC3; RX holds 0x11,0x22 in order; tx_empty=1 at end.
- Underflow: TX empty; one 8-bit frame -> MISO returns 0x00, tx_underflow=1.
- Overflow: RX_DEPTH_LOG2=2; send 5 words, no pops -> 4 words stored (first four), rx_overflow=1; a pop and push in the same cycle while full keeps count=4.
- Abort and reset: CS high after 5 bits -> nothing pushed, next full frame 0x7E is received correctly. Reset asserted mid-word -> all outputs at reset values, next frame is correct.
